abacus_tracker: RTL and testbench

Parametrised, self-contained successor to the ABACuS activation tracker: one shared counter table serves all `N_BANKS` banks, so a row tracked once covers that row in every bank. Each entry holds a row address, an activation count and a per-bank sibling activation vector (SAV). The block sits between the memory controller's ACT path and its refresh scheduler. It emits preventive-refresh requests for the row's two neighbours over a valid/ready handshake and back-pressures ACTs while a request is outstanding. It adds parametrised depth, width, bank count, threshold and counting mode, a saturating spillover counter, and a refresh-window clear.

---
 rtl/abacus_tracker.sv | 173 +++++++++++++++++
 tb/tb_abacus_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/abacus_tracker.sv
`default_nettype none
// ============================================================================
// Module      : abacus_tracker
// Description : Shared-table ACT tracker with sibling activation vectors,
//               saturating spillover and neighbour preventive-refresh requests.
// Revision    : 1.0
// ============================================================================
module abacus_tracker #(
  parameter int N_ENTRY      = 16,
  parameter int ROW_ADDR_BIT = 16,
  parameter int N_BANKS      = 16,
  parameter int CNT_W        = 10,
  parameter int THRESHOLD    = 512,
  parameter int SAV_EN       = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         act_valid_i,
  output logic                         act_ready_o,
  input  logic [ROW_ADDR_BIT-1:0]      row_addr_i,
  input  logic [$clog2(N_BANKS)-1:0]   bank_id_i,
  input  logic                         refw_i,
  output logic                         pref_valid_o,
  input  logic                         pref_ready_i,
  output logic [ROW_ADDR_BIT-1:0]      victim_row_addr_low_o,
  output logic [ROW_ADDR_BIT-1:0]      victim_row_addr_high_o,
  output logic [$clog2(N_BANKS)-1:0]   pref_bank_o,
  output logic                         pref_all_banks_o
);

  localparam int BW = $clog2(N_BANKS);
  localparam int IW = $clog2(N_ENTRY);
  localparam logic [CNT_W-1:0]        c_threshold = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0]        c_spill_max = CNT_W'(THRESHOLD - 1);
  localparam logic [ROW_ADDR_BIT-1:0] c_row_max   = '1;

  logic                    r_valid [N_ENTRY];
  logic [ROW_ADDR_BIT-1:0] r_row   [N_ENTRY];
  logic [CNT_W-1:0]        r_cnt   [N_ENTRY];
  logic [N_BANKS-1:0]      r_sav   [N_ENTRY];
  logic [CNT_W-1:0]        r_spill;

  logic                    r_pref_valid;
  logic [ROW_ADDR_BIT-1:0] r_low;
  logic [ROW_ADDR_BIT-1:0] r_high;
  logic [BW-1:0]           r_bank;

  logic                    w_accept;
  logic [N_BANKS-1:0]      w_onehot;
  logic                    w_hit_any, w_free_any, w_repl_any;
  logic [IW-1:0]           w_hit_idx, w_free_idx, w_repl_idx;
  logic                    w_write, w_inc, w_trig, w_spill_inc;
  logic [IW-1:0]           w_sel_idx;
  logic [CNT_W-1:0]        w_new_cnt;
  logic [N_BANKS-1:0]      w_new_sav;

  assign act_ready_o      = !(r_pref_valid && !pref_ready_i) && !refw_i;
  assign w_accept         = act_valid_i && act_ready_o;
  assign w_onehot         = {{(N_BANKS-1){1'b0}}, 1'b1} << bank_id_i;
  assign pref_all_banks_o = (SAV_EN != 0);

  // Descending scan so the lowest matching index wins each search.
  always_comb begin
    w_hit_any  = 1'b0;
    w_hit_idx  = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_repl_any = 1'b0;
    w_repl_idx = '0;
    for (int e = N_ENTRY - 1; e >= 0; e--) begin
      if (r_valid[e] && (r_row[e] == row_addr_i)) begin
        w_hit_any = 1'b1;
        w_hit_idx = IW'(e);
      end
      if (!r_valid[e]) begin
        w_free_any = 1'b1;
        w_free_idx = IW'(e);
      end
      if (r_valid[e] && (r_cnt[e] == r_spill)) begin
        w_repl_any = 1'b1;
        w_repl_idx = IW'(e);
      end
    end
  end

  always_comb begin
    w_write     = 1'b0;
    w_inc       = 1'b0;
    w_spill_inc = 1'b0;
    w_sel_idx   = w_hit_idx;
    w_new_cnt   = r_cnt[w_hit_idx];
    w_new_sav   = r_sav[w_hit_idx];
    if (w_accept) begin
      if (w_hit_any) begin
        w_write = 1'b1;
        if ((SAV_EN != 0) && !r_sav[w_hit_idx][bank_id_i]) begin
          w_new_sav = r_sav[w_hit_idx] | w_onehot;
        end else begin
          w_inc     = 1'b1;
          w_new_cnt = r_cnt[w_hit_idx] + CNT_W'(1);
          if (SAV_EN != 0) w_new_sav = w_onehot;
        end
      end else if (w_free_any || w_repl_any) begin
        w_write   = 1'b1;
        w_inc     = 1'b1;
        w_sel_idx = w_free_any ? w_free_idx : w_repl_idx;
        w_new_cnt = r_spill + CNT_W'(1);
        w_new_sav = w_onehot;
      end else begin
        w_spill_inc = 1'b1;
      end
    end
    w_trig = w_inc && (w_new_cnt == c_threshold);
    // A triggered entry falls back to the spillover floor rather than zero.
    if (w_trig) begin
      w_new_cnt = r_spill;
      w_new_sav = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int e = 0; e < N_ENTRY; e++) begin
        r_valid[e] <= 1'b0;
        r_row[e]   <= '0;
        r_cnt[e]   <= '0;
        r_sav[e]   <= '0;
      end
      r_spill <= '0;
    end else if (refw_i) begin
      for (int e = 0; e < N_ENTRY; e++) begin
        r_valid[e] <= 1'b0;
        r_cnt[e]   <= '0;
        r_sav[e]   <= '0;
      end
      r_spill <= '0;
    end else begin
      for (int e = 0; e < N_ENTRY; e++) begin
        if (w_write && (w_sel_idx == IW'(e))) begin
          r_valid[e] <= 1'b1;
          r_row[e]   <= row_addr_i;
          r_cnt[e]   <= w_new_cnt;
          r_sav[e]   <= w_new_sav;
        end
      end
      if (w_spill_inc && (r_spill < c_spill_max)) r_spill <= r_spill + CNT_W'(1);
    end
  end

  // A trigger only happens on an accepted ACT, which cannot coincide with a held request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pref_valid <= 1'b0;
      r_low        <= '0;
      r_high       <= '0;
      r_bank       <= '0;
    end else if (w_trig) begin
      r_pref_valid <= 1'b1;
      r_low        <= (row_addr_i == '0) ? '0 : row_addr_i - ROW_ADDR_BIT'(1);
      r_high       <= (row_addr_i == c_row_max) ? c_row_max : row_addr_i + ROW_ADDR_BIT'(1);
      r_bank       <= bank_id_i;
    end else if (r_pref_valid && pref_ready_i) begin
      r_pref_valid <= 1'b0;
    end
  end

  assign pref_valid_o           = r_pref_valid;
  assign victim_row_addr_low_o  = r_low;
  assign victim_row_addr_high_o = r_high;
  assign pref_bank_o            = r_bank;

endmodule
`default_nettype wire

// File: tb/tb_abacus_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_abacus_tracker
// Description : Directed stimulus with a scoreboard of expected refresh requests.
// Revision    : 1.0
// ============================================================================
module tb_abacus_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        act_valid = 1'b0;
  logic        act_ready;
  logic [15:0] row_addr = '0;
  logic [3:0]  bank_id = '0;
  logic        refw = 1'b0;
  logic        pref_valid;
  logic        pref_ready = 1'b1;
  logic [15:0] low, high;
  logic [3:0]  pref_bank;
  logic        pref_all;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  bank;
  } pref_t;

  pref_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  abacus_tracker #(
    .N_ENTRY(4), .ROW_ADDR_BIT(16), .N_BANKS(16), .CNT_W(6), .THRESHOLD(4), .SAV_EN(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .act_valid_i(act_valid), .act_ready_o(act_ready),
    .row_addr_i(row_addr), .bank_id_i(bank_id), .refw_i(refw),
    .pref_valid_o(pref_valid), .pref_ready_i(pref_ready),
    .victim_row_addr_low_o(low), .victim_row_addr_high_o(high),
    .pref_bank_o(pref_bank), .pref_all_banks_o(pref_all)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: samples late in the low phase, pops one expectation per handshake.
  initial begin
    pref_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && pref_valid && pref_ready) begin
        if (exp_q.size() == 0) begin
          chk("pref_unexpected", {31'b0, pref_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pref_low", {16'b0, low}, {16'b0, e.lo});
          chk("pref_high", {16'b0, high}, {16'b0, e.hi});
          chk("pref_bank", {28'b0, pref_bank}, {28'b0, e.bank});
        end
      end
    end
  end

  // Called and returns at a falling edge; trig pushes the hand-given request.
  task automatic act(input logic [15:0] row, input logic [3:0] bank, input bit trig,
                     input logic [15:0] lo, input logic [15:0] hi);
    bit ok = 1'b0;
    act_valid = 1'b1;
    row_addr  = row;
    bank_id   = bank;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (act_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("act_accept_timeout", {31'b0, act_ready}, 32'd1);
    @(posedge clk);
    if (trig) exp_q.push_back('{lo: lo, hi: hi, bank: bank});
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  task automatic actn(input logic [15:0] row, input logic [3:0] bank, input bit trig);
    act(row, bank, trig, row - 16'd1, row + 16'd1);
  endtask

  task automatic do_refw();
    refw = 1'b1;
    @(posedge clk);
    @(negedge clk);
    refw = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_pref_valid", {31'b0, pref_valid}, 32'd0);
    chk("rst_low", {16'b0, low}, 32'd0);
    chk("rst_high", {16'b0, high}, 32'd0);
    chk("rst_bank", {28'b0, pref_bank}, 32'd0);
    chk("rst_act_ready", {31'b0, act_ready}, 32'd1);
    chk("rst_all_banks", {31'b0, pref_all}, 32'd1);
    @(negedge clk);

    // Single row, single bank: alloc cnt=1, increments reach 4 on ACT 4.
    for (int i = 1; i <= 8; i++) begin
      actn(16'h0010, 4'd3, i == 4);
      if (i == 4) begin
        #1;
        chk("t1_pref_valid_next_cycle", {31'b0, pref_valid}, 32'd1);
        chk("t1_low_next_cycle", {16'b0, low}, 32'h0F);
        chk("t1_high_next_cycle", {16'b0, high}, 32'h11);
      end
    end
    // After trigger cnt=0: ACT5 set sav, ACT6..8 give cnt 3, so ACT9 triggers.
    actn(16'h0010, 4'd3, 1'b1);

    // Sibling vector: one ACT per bank keeps cnt=1; repeat on bank 5 increments.
    do_refw();
    for (int b = 0; b < 8; b++) actn(16'h0020, 4'(b), 1'b0);
    actn(16'h0020, 4'd5, 1'b0);
    actn(16'h0020, 4'd6, 1'b0);
    actn(16'h0020, 4'd5, 1'b0);
    actn(16'h0020, 4'd6, 1'b0);
    actn(16'h0020, 4'd5, 1'b1);

    // Spillover: A..D fill the table, E bumps spill, F replaces entry 0 with cnt=2.
    do_refw();
    for (int r = 0; r < 4; r++) actn(16'h0100 + 16'(r), 4'd0, 1'b0);
    actn(16'h0104, 4'd0, 1'b0);
    actn(16'h0105, 4'd0, 1'b0);
    actn(16'h0105, 4'd0, 1'b0);
    actn(16'h0105, 4'd0, 1'b1);
    actn(16'h0101, 4'd0, 1'b0);
    actn(16'h0101, 4'd0, 1'b0);
    actn(16'h0101, 4'd0, 1'b1);

    // Boundaries plus back-to-back triggers with the scheduler always ready.
    do_refw();
    for (int i = 0; i < 3; i++) begin
      act(16'h0000, 4'd9, 1'b0, 16'h0000, 16'h0001);
      act(16'hFFFF, 4'd9, 1'b0, 16'hFFFE, 16'hFFFF);
    end
    act(16'h0000, 4'd9, 1'b1, 16'h0000, 16'h0001);
    act(16'hFFFF, 4'd9, 1'b1, 16'hFFFE, 16'hFFFF);
    #1;
    chk("b2b_second_pending", {31'b0, pref_valid}, 32'd1);
    @(negedge clk);

    // Back-pressure: request held five cycles, ACTs blocked, released on cycle 6.
    do_refw();
    pref_ready = 1'b0;
    for (int i = 0; i < 3; i++) actn(16'h0200, 4'd2, 1'b0);
    actn(16'h0200, 4'd2, 1'b1);
    act_valid = 1'b1;
    row_addr  = 16'h0777;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_pref_valid", {31'b0, pref_valid}, 32'd1);
      chk("bp_low", {16'b0, low}, 32'h01FF);
      chk("bp_high", {16'b0, high}, 32'h0201);
      chk("bp_bank", {28'b0, pref_bank}, 32'd2);
      chk("bp_act_ready", {31'b0, act_ready}, 32'd0);
      @(negedge clk);
    end
    act_valid  = 1'b0;
    pref_ready = 1'b1;
    #1;
    chk("bp_release_act_ready", {31'b0, act_ready}, 32'd1);
    @(negedge clk);
    #1;
    chk("bp_cleared", {31'b0, pref_valid}, 32'd0);
    @(negedge clk);

    // refw coincident with an ACT to a hot row: ACT blocked, table cleared.
    do_refw();
    for (int i = 0; i < 3; i++) actn(16'h0050, 4'd0, 1'b0);
    refw      = 1'b1;
    act_valid = 1'b1;
    row_addr  = 16'h0050;
    bank_id   = 4'd0;
    #1;
    chk("refw_act_ready", {31'b0, act_ready}, 32'd0);
    @(negedge clk);
    refw      = 1'b0;
    act_valid = 1'b0;
    #1;
    chk("refw_no_pref", {31'b0, pref_valid}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) actn(16'h0050, 4'd0, 1'b0);
    actn(16'h0050, 4'd0, 1'b1);

    // Asynchronous reset drops a held request before any clock edge.
    do_refw();
    pref_ready = 1'b0;
    for (int i = 0; i < 4; i++) actn(16'h0300, 4'd1, 1'b0);
    #1;
    chk("arst_pref_before", {31'b0, pref_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pref_valid", {31'b0, pref_valid}, 32'd0);
    chk("arst_low", {16'b0, low}, 32'd0);
    chk("arst_act_ready", {31'b0, act_ready}, 32'd1);
    @(negedge clk);
    rst_n      = 1'b1;
    pref_ready = 1'b1;
    for (int i = 0; i < 3; i++) actn(16'h0300, 4'd1, 1'b0);
    actn(16'h0300, 4'd1, 1'b1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
